// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect_ctrl
// Description : Fetch-stage sequencer. It owns the fetch PC, issues in-order
//               instruction-memory requests under a credit limit, and pairs
//               each response with its PC in a small instruction buffer for
//               decode. An execute-stage redirect reloads the PC, flushes the
//               buffer and drops responses still in flight from the old path.
//
// Ports       : clk, rst_n                 clock / async active-low reset
//               redirect_valid_in/_pc_in   redirect from branch resolution
//               imem_req_valid_out/_addr_out, imem_req_ready_in
//                                          request channel (addr = fetch PC)
//               imem_rsp_valid_in/_data_in in-order response, always accepted
//               instr_valid_out/instr_out/instr_pc_out, instr_ready_in
//                                          first-word-fall-through to decode
//               flush_out                  one-cycle IF/ID kill after redirect
//               misalign_trap_out          sticky trap (MISALIGN_TRAP_EN only)
//
// Build macro : MISALIGN_TRAP_EN - misaligned redirect halts fetch and raises
//               misalign_trap_out. Undefined: redirect_pc_in[1:0] is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req_valid_out,
    output logic [31:0] imem_req_addr_out,
    input  logic        imem_req_ready_in,
    input  logic        imem_rsp_valid_in,
    input  logic [31:0] imem_rsp_data_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    input  logic        instr_ready_in,
    output logic        flush_out
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap_out
`endif
);

    localparam int              PW          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0]      c_MAX       = 4'(MAX_OUTSTANDING);
    localparam logic [PW-1:0]   c_LAST      = PW'(MAX_OUTSTANDING - 1);

    localparam logic [1:0]      c_ST_BOOT   = 2'd0;
    localparam logic [1:0]      c_ST_RUN    = 2'd1;
    localparam logic [1:0]      c_ST_HALT   = 2'd2;

    logic [1:0]     r_state;
    logic [31:0]    r_pc;
    logic [2:0]     r_outstanding;
    logic [2:0]     r_drop_cnt;
    logic           r_flush;

    // PCs of accepted requests, consumed in order by responses
    logic [31:0]    r_pcq [MAX_OUTSTANDING];
    logic [PW-1:0]  r_pcq_wr;
    logic [PW-1:0]  r_pcq_rd;

    // Instruction buffer towards decode
    logic [31:0]    r_buf_data [MAX_OUTSTANDING];
    logic [31:0]    r_buf_pc   [MAX_OUTSTANDING];
    logic [PW-1:0]  r_buf_wr;
    logic [PW-1:0]  r_buf_rd;
    logic [2:0]     r_buf_count;

    logic           w_accept;
    logic           w_rsp;
    logic           w_push;
    logic           w_pop;
    logic           w_misaligned;
    logic [31:0]    w_target;
    logic [2:0]     w_outstanding_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic r_trap;
    assign w_misaligned      = (redirect_pc_in[1:0] != 2'b00);
    assign w_target          = redirect_pc_in;
    assign misalign_trap_out = r_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else if (redirect_valid_in) begin
            r_trap <= w_misaligned;
        end
    end
`else
    assign w_misaligned = 1'b0;
    assign w_target     = redirect_pc_in & 32'hFFFF_FFFC;
`endif

    // Credits cover both in-flight requests and buffered instructions, so a
    // response can always be buffered without back-pressure.
    assign imem_req_valid_out = (r_state == c_ST_RUN) &&
                                (({1'b0, r_outstanding} + {1'b0, r_buf_count}) < c_MAX);
    assign imem_req_addr_out  = r_pc;
    assign w_accept           = imem_req_valid_out && imem_req_ready_in;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp  = imem_rsp_valid_in && (r_outstanding != 3'd0);
    assign w_push = w_rsp && !redirect_valid_in && (r_drop_cnt == 3'd0);
    assign w_pop  = instr_valid_out && instr_ready_in;

    assign w_outstanding_nxt = r_outstanding + {2'b00, w_accept} - {2'b00, w_rsp};

    assign instr_valid_out = (r_buf_count != 3'd0);
    assign instr_out       = r_buf_data[r_buf_rd];
    assign instr_pc_out    = r_buf_pc[r_buf_rd];
    assign flush_out       = r_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_BOOT;
        end else if (redirect_valid_in) begin
            r_state <= w_misaligned ? c_ST_HALT : c_ST_RUN;
        end else if (r_state == c_ST_BOOT) begin
            r_state <= c_ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid_in) begin
            if (!w_misaligned) begin
                r_pc <= w_target;
            end
        end else if (w_accept) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Everything still in flight after this cycle belongs to the old path,
    // including a request accepted alongside the redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= 3'd0;
            r_drop_cnt    <= 3'd0;
            r_flush       <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_flush       <= redirect_valid_in;
            if (redirect_valid_in) begin
                r_drop_cnt <= w_outstanding_nxt;
            end else if (w_rsp && (r_drop_cnt != 3'd0)) begin
                r_drop_cnt <= r_drop_cnt - 3'd1;
            end
        end
    end

    // PC queue is never flushed: dropped responses still retire their entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcq_wr <= '0;
            r_pcq_rd <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_pcq[i] <= 32'd0;
            end
        end else begin
            if (w_accept) begin
                r_pcq[r_pcq_wr] <= r_pc;
                r_pcq_wr        <= ptr_inc(r_pcq_wr);
            end
            if (w_rsp) begin
                r_pcq_rd <= ptr_inc(r_pcq_rd);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_wr    <= '0;
            r_buf_rd    <= '0;
            r_buf_count <= 3'd0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_buf_data[i] <= 32'd0;
                r_buf_pc[i]   <= 32'd0;
            end
        end else if (redirect_valid_in) begin
            r_buf_wr    <= '0;
            r_buf_rd    <= '0;
            r_buf_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_buf_wr] <= imem_rsp_data_in;
                r_buf_pc[r_buf_wr]   <= r_pcq[r_pcq_rd];
                r_buf_wr             <= ptr_inc(r_buf_wr);
            end
            if (w_pop) begin
                r_buf_rd <= ptr_inc(r_buf_rd);
            end
            r_buf_count <= r_buf_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_redirect_ctrl
// Description : Randomized self-checking bench for fetch_redirect_ctrl. A
//               queue-based reference model tags every in-flight fetch as
//               live or dead; a redirect kills all of them and empties the
//               decode queue. A simple in-order memory answers requests with
//               random latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_OUT  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'd0;
    logic        imem_req_valid_out;
    logic [31:0] imem_req_addr_out;
    logic        imem_req_ready_in = 1'b0;
    logic        imem_rsp_valid_in = 1'b0;
    logic [31:0] imem_rsp_data_in = 32'd0;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_ready_in = 1'b0;
    logic        flush_out;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap_out;
`endif

    fetch_redirect_ctrl #(
        .RESET_PC        (RESET_PC),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .redirect_valid_in  (redirect_valid_in),
        .redirect_pc_in     (redirect_pc_in),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_addr_out  (imem_req_addr_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_rsp_valid_in  (imem_rsp_valid_in),
        .imem_rsp_data_in   (imem_rsp_data_in),
        .instr_valid_out    (instr_valid_out),
        .instr_out          (instr_out),
        .instr_pc_out       (instr_pc_out),
        .instr_ready_in     (instr_ready_in),
        .flush_out          (flush_out)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_trap_out  (misalign_trap_out)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic        live;
    } fetch_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } instr_t;

    fetch_t      m_fl[$];     // fetches issued, awaiting response
    instr_t      m_buf[$];    // instructions waiting for decode
    logic [31:0] m_pc;
    bit          m_boot, m_halt, m_trap, m_flush;
    logic [31:0] mem_q[$];    // memory side: addresses to answer, in order

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0:       return $urandom & 32'hFFFF_FFFC;
            1:       return 32'hFFFF_FFF8;
            2:       return $urandom;
            default: return 32'h0000_0100;
        endcase
    endfunction

    task automatic model_reset();
        m_fl.delete();
        m_buf.delete();
        mem_q.delete();
        m_pc    = RESET_PC;
        m_boot  = 1;
        m_halt  = 0;
        m_trap  = 0;
        m_flush = 0;
    endtask

    // One clock: check outputs at the negedge, drive inputs, advance model.
    task automatic cycle(input int p_rdy, input int p_irdy, input int p_redir,
                         input int p_rsp, input bit rogue);
        bit     exp_rv, acc, mem_acc;
        fetch_t f;
        exp_rv = !m_boot && !m_halt && ((m_fl.size() + m_buf.size()) < MAX_OUT);
        check("req_valid", 32'(imem_req_valid_out), 32'(exp_rv));
        check("req_addr", imem_req_addr_out, m_pc);
        check("instr_valid", 32'(instr_valid_out), 32'(m_buf.size() != 0));
        if (m_buf.size() != 0) begin
            check("instr_pc", instr_pc_out, m_buf[0].pc);
            check("instr", instr_out, m_buf[0].data);
        end
        check("flush", 32'(flush_out), 32'(m_flush));
`ifdef MISALIGN_TRAP_EN
        check("trap", 32'(misalign_trap_out), 32'(m_trap));
`endif
        // drive
        imem_req_ready_in = ($urandom_range(99) < p_rdy);
        instr_ready_in    = ($urandom_range(99) < p_irdy);
        redirect_valid_in = ($urandom_range(99) < p_redir);
        redirect_pc_in    = pick_target();
        imem_rsp_valid_in = 1'b0;
        imem_rsp_data_in  = $urandom;
        if (mem_q.size() != 0) begin
            if ($urandom_range(99) < p_rsp) begin
                imem_rsp_valid_in = 1'b1;
                imem_rsp_data_in  = mem_word(mem_q.pop_front());
            end
        end else if (rogue && ($urandom_range(99) < 3)) begin
            imem_rsp_valid_in = 1'b1;
        end
        mem_acc = imem_req_valid_out && imem_req_ready_in;
        if (mem_acc) mem_q.push_back(imem_req_addr_out);

        // advance model over the coming rising edge
        acc = exp_rv && imem_req_ready_in;
        if (m_buf.size() != 0 && instr_ready_in) void'(m_buf.pop_front());
        if (imem_rsp_valid_in && m_fl.size() != 0) begin
            f = m_fl.pop_front();
            if (f.live && !redirect_valid_in)
                m_buf.push_back('{data: imem_rsp_data_in, pc: f.pc});
        end
        if (acc) m_fl.push_back('{pc: m_pc, live: 1'b1});
        m_flush = redirect_valid_in;
        m_boot  = 0;
        if (redirect_valid_in) begin
            foreach (m_fl[i]) m_fl[i].live = 1'b0;
            m_buf.delete();
`ifdef MISALIGN_TRAP_EN
            if (redirect_pc_in[1:0] != 2'b00) begin
                m_halt = 1;
                m_trap = 1;
            end else begin
                m_halt = 0;
                m_trap = 0;
                m_pc   = redirect_pc_in;
            end
`else
            m_pc = {redirect_pc_in[31:2], 2'b00};
`endif
        end else if (acc) begin
            m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n             = 1'b0;
        redirect_valid_in = 1'b0;
        imem_req_ready_in = 1'b0;
        imem_rsp_valid_in = 1'b0;
        instr_ready_in    = 1'b0;
        #1;
        model_reset();
        check("rst_req_valid", 32'(imem_req_valid_out), 32'd0);
        check("rst_req_addr", imem_req_addr_out, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid_out), 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_instr_pc", instr_pc_out, 32'd0);
        check("rst_flush", 32'(flush_out), 32'd0);
`ifdef MISALIGN_TRAP_EN
        check("rst_trap", 32'(misalign_trap_out), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // straight-line fetch, everything ready
        for (int i = 0; i < 60; i++) cycle(100, 100, 0, 100, 0);
        // decode stalled: credits run out
        for (int i = 0; i < 20; i++) cycle(100, 0, 0, 100, 0);
        for (int i = 0; i < 20; i++) cycle(100, 100, 0, 100, 0);
        // random traffic with occasional redirects
        for (int i = 0; i < 2000; i++) cycle(70, 60, 10, 50, 1);
        // bursts of back-to-back redirects
        for (int i = 0; i < 200; i++) cycle(80, 70, 60, 60, 0);
        // reset in the middle of activity
        for (int i = 0; i < 30; i++) cycle(80, 50, 5, 60, 0);
        do_reset();
        for (int i = 0; i < 1500; i++) cycle(60, 50, 8, 40, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
